pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 6-stage MIPS pipeline (PC, IF, ID, EX, MEM, WB).
//  Merges per-stage stall requests into one stall vector; runs the multi-cycle mul/div stall window for EX.
//  Turns an exception request into a timed flush plus redirect PC.
//  Sits beside the stage registers; every pipeline register obeys its stall and flush outputs.
// PARAMETERS
//  MDIV_CYCLES       32  EX busy cycles for a mul/div op (>=2)
//  EXC_FLUSH_CYCLES  1   cycles flush stays asserted per exception (>=1)
// PORTS
//  clk             in   1   rising-edge clock
//  rst             in   1   reset, synchronous, active-high
//  stallreq_if     in   1   IF needs hold (icache miss)
//  stallreq_id     in   1   ID needs hold (load-use hazard)
//  stallreq_ex     in   1   EX needs hold (single-cycle extension)
//  stallreq_mem    in   1   MEM needs hold (dcache/bus wait)
//  mdiv_start      in   1   EX presents a mul/div op this cycle
//  exc_valid       in   1   MEM commits an exception this cycle
//  exc_pc          in   32  handler address (Inst_addr_t), valid with exc_valid
//  stall           out  6   Stall_t; bit0=PC ... bit5=WB; 1 = hold stage register
//  flush           out  1   clear all stage registers to NOP
//  new_pc          out  32  redirect target, valid while flush=1
//  mdiv_busy       out  1   mul/div window active
//  mdiv_done       out  1   1-cycle pulse: EX may capture mul/div result
// BEHAVIOUR
//  Reset: state IDLE, counters 0; stall=0, flush=0, new_pc=0, mdiv_busy=0, mdiv_done=0.
//  FSM states IDLE, MDIV, MDIV_DONE, FLUSH; flush/new_pc/mdiv_* decoded from registered state.
//  stall is combinational from requests + state (zero-cycle response, needed for load-use).
//  Stall rule: request from stage k sets stall[0..k], stall[k+1..5]=0 (bubble into k+1).
//   Stage index: IF=1, ID=2, EX=3, MEM=4; highest active stage wins (MEM>EX>ID>IF).
//  IDLE: mdiv_start & !exc_valid -> MDIV; counter <= MDIV_CYCLES-1; stall=6'b001111 this cycle.
//  MDIV: mdiv_busy=1; stall = 6'b001111 OR'd with stall-rule vector (MEM req -> 6'b011111).
//   Counter decrements every cycle, including cycles where MEM also stalls.
//   At counter==0 -> MDIV_DONE; mdiv_start ignored while busy.
//  MDIV_DONE: mdiv_done=1 for exactly one cycle; EX-imposed stall released (stall from requests only).
//   Then -> IDLE; a fresh mdiv_start here is accepted next cycle, not this one.
//  Exception: exc_valid in IDLE/MDIV/MDIV_DONE -> FLUSH next cycle; exc_pc latched into new_pc.
//   An active mul/div is aborted: no mdiv_done pulse, counter cleared.
//  FLUSH: flush=1, stall=6'b0, new_pc held, for EXC_FLUSH_CYCLES cycles, then -> IDLE (flush=0).
//   All stallreq_*, mdiv_start and exc_valid ignored while in FLUSH.
//  Simultaneous exc_valid & mdiv_start in IDLE: exception wins, mul/div not started.
//  Reset mid-operation: returns to IDLE next edge; no flush/done pulse emitted.
//  new_pc keeps last handler value outside FLUSH (don't-care for consumers).
// STRUCTURE
//  cpu_defines package: Stall_t (logic [5:0]); STAGE_PC..STAGE_WB index constants;
//   Ctrl_state_t enum {CTRL_IDLE, CTRL_MDIV, CTRL_MDIV_DONE, CTRL_FLUSH};
//   STALL_NONE, STALL_TO_EX (6'b001111), STALL_TO_MEM (6'b011111) constants.
//  One sub-module: pipeline_ctrl_cnt -- loadable down-counter (load, value, en, zero flag),
//   width $clog2(max(MDIV_CYCLES, EXC_FLUSH_CYCLES)); shared by MDIV and FLUSH states.
// TESTING
//  1 stallreq_id=1 alone, IDLE -> stall=6'b000111 same cycle, flush=0; stallreq_if only -> 6'b000011.
//  2 stallreq_id=1 & stallreq_mem=1 -> stall=6'b011111 (MEM priority); drop both -> 6'b000000.
//  3 mdiv_start pulse, MDIV_CYCLES=32 -> mdiv_busy=1 for 32 cycles, stall=6'b001111 throughout,
//    mdiv_done=1 on cycle 33 only with stall=0, IDLE after; 2nd mdiv_start while busy ignored.
//  4 exc_valid=1, exc_pc=32'hBFC00380 at mdiv cycle 10 -> next cycle flush=1, new_pc=32'hBFC00380,
//    stall=0, mdiv_busy=0; no mdiv_done ever; IDLE after EXC_FLUSH_CYCLES.
//  5 exc_valid & mdiv_start same cycle in IDLE -> FLUSH taken, mdiv_busy stays 0.
//  6 rst=1 during MDIV and during FLUSH -> next edge all outputs 0, state IDLE;
//    with rst low, stallreq_mem during MDIV -> 6'b011111, total mdiv window still 32 cycles.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline control types: stall vector layout, stage indices and sequencer states.
// Stall constants are prefix masks: holding stage k also holds every stage upstream of it.
package pipeline_ctrl_pkg;

    typedef logic [5:0] Stall_t;

    localparam int STAGE_PC  = 0;
    localparam int STAGE_IF  = 1;
    localparam int STAGE_ID  = 2;
    localparam int STAGE_EX  = 3;
    localparam int STAGE_MEM = 4;
    localparam int STAGE_WB  = 5;

    typedef enum logic [1:0] {
        CTRL_IDLE      = 2'd0,
        CTRL_MDIV      = 2'd1,
        CTRL_MDIV_DONE = 2'd2,
        CTRL_FLUSH     = 2'd3
    } Ctrl_state_t;

    localparam Stall_t STALL_NONE   = 6'b000000;
    localparam Stall_t STALL_TO_IF  = Stall_t'((32'd1 << (STAGE_IF + 1)) - 32'd1);
    localparam Stall_t STALL_TO_ID  = Stall_t'((32'd1 << (STAGE_ID + 1)) - 32'd1);
    localparam Stall_t STALL_TO_EX  = Stall_t'((32'd1 << (STAGE_EX + 1)) - 32'd1);
    localparam Stall_t STALL_TO_MEM = Stall_t'((32'd1 << (STAGE_MEM + 1)) - 32'd1);

    // Most downstream requester wins; its successor receives a bubble.
    function automatic Stall_t stall_from_req(
        input logic req_if,
        input logic req_id,
        input logic req_ex,
        input logic req_mem
    );
        Stall_t v;
        if (req_mem) begin
            v = STALL_TO_MEM;
        end else if (req_ex) begin
            v = STALL_TO_EX;
        end else if (req_id) begin
            v = STALL_TO_ID;
        end else if (req_if) begin
            v = STALL_TO_IF;
        end else begin
            v = STALL_NONE;
        end
        return v;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_cnt.sv
// Loadable down-counter that saturates at zero; times both the mul/div window and the flush window.
module pipeline_ctrl_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Count register: load has priority over decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= {W{1'b0}};
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_en && (r_count != {W{1'b0}})) begin
            r_count <= r_count - W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = (r_count == {W{1'b0}});

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 6-stage pipeline: merges stage stall requests, times the
// mul/div EX window and converts a committed exception into a flush with redirect PC.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MDIV_CYCLES      = 32,
    parameter int EXC_FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        mdiv_start,
    input  logic        exc_valid,
    input  logic [31:0] exc_pc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        mdiv_busy,
    output logic        mdiv_done
);

    localparam int CNT_MAX = (MDIV_CYCLES > EXC_FLUSH_CYCLES) ? MDIV_CYCLES : EXC_FLUSH_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] MDIV_LOAD  = CNT_W'(MDIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(EXC_FLUSH_CYCLES - 1);

    Ctrl_state_t      r_state;
    Ctrl_state_t      w_next_state;
    logic [31:0]      r_new_pc;
    logic             w_cnt_load;
    logic             w_cnt_en;
    logic             w_cnt_zero;
    logic [CNT_W-1:0] w_cnt_value;
    logic             w_exc_take;
    logic             w_mdiv_take;
    Stall_t           w_req_stall;

    // Nothing is accepted during FLUSH; a mul/div only starts from IDLE and loses to an exception.
    assign w_exc_take  = exc_valid && (r_state != CTRL_FLUSH);
    assign w_mdiv_take = mdiv_start && !exc_valid && (r_state == CTRL_IDLE);
    assign w_req_stall = stall_from_req(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
    assign new_pc      = r_new_pc;

    pipeline_ctrl_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_cnt_load),
        .i_value (w_cnt_value),
        .i_en    (w_cnt_en),
        .o_zero  (w_cnt_zero)
    );

    // State register and handler address capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= CTRL_IDLE;
            r_new_pc <= 32'h0000_0000;
        end else begin
            r_state <= w_next_state;
            if (w_exc_take) begin
                r_new_pc <= exc_pc;
            end else begin
                r_new_pc <= r_new_pc;
            end
        end
    end

    // Next-state and counter control; an exception reloads the counter, aborting any mul/div.
    always_comb begin
        w_next_state = r_state;
        w_cnt_load   = 1'b0;
        w_cnt_en     = 1'b0;
        w_cnt_value  = FLUSH_LOAD;
        case (r_state)
            CTRL_IDLE: begin
                if (w_exc_take) begin
                    w_next_state = CTRL_FLUSH;
                    w_cnt_load   = 1'b1;
                    w_cnt_value  = FLUSH_LOAD;
                end else if (w_mdiv_take) begin
                    w_next_state = CTRL_MDIV;
                    w_cnt_load   = 1'b1;
                    w_cnt_value  = MDIV_LOAD;
                end else begin
                    w_next_state = CTRL_IDLE;
                end
            end
            CTRL_MDIV: begin
                if (w_exc_take) begin
                    w_next_state = CTRL_FLUSH;
                    w_cnt_load   = 1'b1;
                    w_cnt_value  = FLUSH_LOAD;
                end else if (w_cnt_zero) begin
                    w_next_state = CTRL_MDIV_DONE;
                end else begin
                    w_next_state = CTRL_MDIV;
                    w_cnt_en     = 1'b1;
                end
            end
            CTRL_MDIV_DONE: begin
                if (w_exc_take) begin
                    w_next_state = CTRL_FLUSH;
                    w_cnt_load   = 1'b1;
                    w_cnt_value  = FLUSH_LOAD;
                end else begin
                    w_next_state = CTRL_IDLE;
                end
            end
            CTRL_FLUSH: begin
                if (w_cnt_zero) begin
                    w_next_state = CTRL_IDLE;
                end else begin
                    w_next_state = CTRL_FLUSH;
                    w_cnt_en     = 1'b1;
                end
            end
            default: begin
                w_next_state = CTRL_IDLE;
            end
        endcase
    end

    // Output decode; stall stays combinational so a load-use hold takes effect this cycle.
    always_comb begin
        stall     = STALL_NONE;
        flush     = 1'b0;
        mdiv_busy = 1'b0;
        mdiv_done = 1'b0;
        case (r_state)
            CTRL_IDLE: begin
                stall = w_req_stall | (w_mdiv_take ? STALL_TO_EX : STALL_NONE);
            end
            CTRL_MDIV: begin
                stall     = w_req_stall | STALL_TO_EX;
                mdiv_busy = 1'b1;
            end
            CTRL_MDIV_DONE: begin
                stall     = w_req_stall;
                mdiv_done = 1'b1;
            end
            CTRL_FLUSH: begin
                stall = STALL_NONE;
                flush = 1'b1;
            end
            default: begin
                stall = STALL_NONE;
            end
        endcase
        if (rst) begin
            stall = STALL_NONE;
        end else begin
            stall = stall;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        mdiv_start, exc_valid;
    logic [31:0] exc_pc;
    logic [5:0]  stall;
    logic        flush, mdiv_busy, mdiv_done;
    logic [31:0] new_pc;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        rst, rif, rid, rex, rmem, ms, ev;
        logic [31:0] pc;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        logic        e_busy, e_done;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .MDIV_CYCLES      (32),
        .EXC_FLUSH_CYCLES (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .mdiv_start   (mdiv_start),
        .exc_valid    (exc_valid),
        .exc_pc       (exc_pc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .mdiv_busy    (mdiv_busy),
        .mdiv_done    (mdiv_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rif, input logic rid, input logic rex,
                         input logic rmem, input logic ms, input logic ev, input logic [31:0] pc);
        rst = r; stallreq_if = rif; stallreq_id = rid; stallreq_ex = rex;
        stallreq_mem = rmem; mdiv_start = ms; exc_valid = ev; exc_pc = pc;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [5:0] e_stall, input logic e_flush,
                           input logic [31:0] e_pc, input logic e_busy, input logic e_done);
        chk({tag, "_stall"}, {26'd0, stall}, {26'd0, e_stall});
        chk({tag, "_flush"}, {31'd0, flush}, {31'd0, e_flush});
        chk({tag, "_new_pc"}, new_pc, e_pc);
        chk({tag, "_busy"}, {31'd0, mdiv_busy}, {31'd0, e_busy});
        chk({tag, "_done"}, {31'd0, mdiv_done}, {31'd0, e_done});
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000111, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000011, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 6'b011111, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 6'b011111, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 6'b011111, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0};
        // exception and mul/div together in IDLE: exception wins, mdiv_start in FLUSH ignored
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0180, 6'b000111, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 6'b000000, 1'b1, 32'h8000_0180, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h8000_0180, 1'b0, 1'b0};

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rst, vecs[i].rif, vecs[i].rid, vecs[i].rex, vecs[i].rmem,
                  vecs[i].ms, vecs[i].ev, vecs[i].pc);
            @(negedge clk);
            chk_all($sformatf("v%0d", i), vecs[i].e_stall, vecs[i].e_flush, vecs[i].e_pc,
                    vecs[i].e_busy, vecs[i].e_done);
            cyc();
        end

        // Full 32-cycle mul/div window, with a second start ignored mid-window
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk_all("md_start", 6'b001111, 1'b0, 32'h8000_0180, 1'b0, 1'b0);
        cyc();
        busy_cnt = 0;
        for (int i = 1; i <= 32; i++) begin
            mdiv_start = (i == 5);
            @(negedge clk);
            if (mdiv_busy === 1'b1 && stall === 6'b001111 && mdiv_done === 1'b0) busy_cnt++;
            cyc();
        end
        chk("md_window_cycles", busy_cnt, 32);
        mdiv_start = 1'b1;
        @(negedge clk);
        chk_all("md_done", 6'b000000, 1'b0, 32'h8000_0180, 1'b0, 1'b1);
        cyc();
        @(negedge clk);
        chk_all("md_restart", 6'b001111, 1'b0, 32'h8000_0180, 1'b0, 1'b0);
        cyc();

        // Exception at mul/div cycle 10 aborts the window
        mdiv_start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 10) begin
                exc_valid = 1'b1;
                exc_pc    = 32'hBFC0_0380;
            end
            @(negedge clk);
            if (i == 10) chk_all("abort_exc", 6'b001111, 1'b0, 32'h8000_0180, 1'b1, 1'b0);
            cyc();
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk_all("abort_flush", 6'b000000, 1'b1, 32'hBFC0_0380, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mdiv_busy !== 1'b0 || flush !== 1'b0) busy_cnt++;
            if (mdiv_done !== 1'b0) done_cnt++;
            cyc();
        end
        chk("abort_no_activity", busy_cnt, 0);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_pc_held", new_pc, 32'hBFC0_0380);

        // Reset in the middle of a mul/div window
        mdiv_start = 1'b1;
        cyc();
        mdiv_start = 1'b0;
        repeat (5) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk_all("rst_mdiv", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc();

        // Reset while flushing
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
        cyc();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("rst_in_flush_flag", {31'd0, flush}, 32'd1);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk_all("rst_flush", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc();

        // MEM stall overlapping the mul/div window does not stretch it
        mdiv_start = 1'b1;
        cyc();
        mdiv_start = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            stallreq_mem = (i >= 3 && i <= 8);
            @(negedge clk);
            if (mdiv_busy === 1'b1) busy_cnt++;
            if (mdiv_done === 1'b1) done_cnt++;
            if (i == 5) chk("mem_in_mdiv_stall", {26'd0, stall}, {26'd0, 6'b011111});
            if (i == 10) chk("mdiv_after_mem_stall", {26'd0, stall}, {26'd0, 6'b001111});
            if (i == 33) chk("mem_mdiv_done_at_33", {31'd0, mdiv_done}, 32'd1);
            cyc();
        end
        chk("mem_mdiv_busy_cycles", busy_cnt, 32);
        chk("mem_mdiv_done_pulses", done_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
